// File: rtl/osc_pkg.sv
// Shared oscilloscope datapath definitions: default widths, capture FSM states
// and the saturating subtract used to derive the re-arm threshold.
package osc_pkg;

  localparam int DW = 12;
  localparam int AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    READY,
    CAPTURE,
    DONE
  } state_e;

  function automatic int unsigned satSub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/trig_capture_if.sv
// Sample stream, control and record read-back signals of the trigger/capture block.
interface trig_capture_if #(
  parameter int DW = osc_pkg::DW,
  parameter int AW = osc_pkg::AW
);

  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [DW-1:0] level;
  logic [DW-1:0] amp;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          auto_trig;

  modport master (
    output sample_valid, sample, level, amp, arm, rd_addr,
    input  rd_data, busy, done, auto_trig
  );

  modport slave (
    input  sample_valid, sample, level, amp, arm, rd_addr,
    output rd_data, busy, done, auto_trig
  );

endinterface

// File: rtl/trig_capture_ram.sv
// Simple dual-port record buffer: one write port, one registered read port.
// Same-address write/read returns the old word.
module capture_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; the array itself stays uncleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/trig_capture.sv
// Hysteresis trigger plus fixed-length record capture for the scope datapath.
// Optional macro PRETRIG_EN keeps a circular pre-trigger history of DEPTH/2 samples.
module trig_capture #(
  parameter int DW      = osc_pkg::DW,
  parameter int DEPTH   = 256,
  parameter int AW      = osc_pkg::AW,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  trig_capture_if.slave bus
);

  import osc_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          auto_q, auto_d;
  logic          we;
  logic [AW-1:0] lastPtr;
  logic [AW-1:0] rdAddr;
  logic [DW:0]   loThr;
  logic          belowLo;
  logic          levelHit;
  logic          timeoutHit;

  assign loThr      = (DW+1)'(satSub(32'(bus.level), 32'(HYST)));
  assign belowLo    = {1'b0, bus.sample} < loThr;
  // A DC input (tiny amplitude) must never trigger on level, only on timeout.
  assign levelHit   = (32'(bus.amp) >= 32'(HYST)) && (bus.sample >= bus.level);
  assign timeoutHit = cnt_q == CW'(TIMEOUT - 1);

`ifdef PRETRIG_EN
  logic [AW-1:0] start_q, start_d;

  assign lastPtr = start_q - AW'(1);
  assign rdAddr  = bus.rd_addr + start_q;
`else
  assign lastPtr = '1;
  assign rdAddr  = bus.rd_addr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wrPtr_q <= '0;
      cnt_q   <= '0;
      auto_q  <= 1'b0;
`ifdef PRETRIG_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wrPtr_q <= wrPtr_d;
      cnt_q   <= cnt_d;
      auto_q  <= auto_d;
`ifdef PRETRIG_EN
      start_q <= start_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wrPtr_d = wrPtr_q;
    cnt_d   = cnt_q;
    auto_d  = auto_q;
    we      = 1'b0;
`ifdef PRETRIG_EN
    start_d = start_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d = ARMED;
          cnt_d   = '0;
          wrPtr_d = '0;
          auto_d  = 1'b0;
        end
      end

      ARMED, READY: begin
        if (bus.sample_valid) begin
`ifdef PRETRIG_EN
          we      = 1'b1;
          wrPtr_d = wrPtr_q + AW'(1);
`endif
          // Timeout wins over the ARMED->READY step so the counter cannot overrun.
          if (state_q == READY && levelHit) begin
            state_d = CAPTURE;
            auto_d  = 1'b0;
          end else if (timeoutHit) begin
            state_d = CAPTURE;
            auto_d  = 1'b1;
          end else if (state_q == ARMED && belowLo) begin
            state_d = READY;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end

          if (state_d == CAPTURE) begin
            we      = 1'b1;
            wrPtr_d = wrPtr_q + AW'(1);
`ifdef PRETRIG_EN
            start_d = wrPtr_q - AW'(DEPTH / 2);
`endif
          end
        end
      end

      CAPTURE: begin
        if (bus.sample_valid) begin
          we      = 1'b1;
          wrPtr_d = wrPtr_q + AW'(1);
          if (wrPtr_q == lastPtr) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.arm) begin
          state_d = ARMED;
          cnt_d   = '0;
          wrPtr_d = '0;
          auto_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == ARMED) || (state_q == READY) || (state_q == CAPTURE);
  assign bus.done      = (state_q == DONE);
  assign bus.auto_trig = auto_q && (state_q == DONE);

  capture_ram #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(wrPtr_q),
    .wdata_i(bus.sample),
    .raddr_i(rdAddr),
    .rdata_o(bus.rd_data)
  );

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture; with PRETRIG_EN defined it runs the
// pre-trigger record check instead of the post-trigger scenarios.
module tb_trig_capture;

  logic clk;
  logic rst_n;
  int   applied;
  int   miscompares;

  trig_capture_if #(.DW(12), .AW(8)) bus ();

  trig_capture #(
    .DW     (12),
    .DEPTH  (256),
    .AW     (8),
    .HYST   (8),
    .TIMEOUT(200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendSample(input logic [11:0] v);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample       = v;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic armPulse();
    @(negedge clk);
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic readWord(input logic [7:0] a, output logic [11:0] d);
    bus.rd_addr = a;
    @(negedge clk);
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    applied++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    applied++;
    if (bus.done !== 1'b0 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done_auto: got %b/%b expected 0/0", bus.done, bus.auto_trig);
    end
    applied++;
    if (bus.rd_data !== 12'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_data: got %0d expected 0", bus.rd_data);
    end
    rst_n = 1'b1;
    bus.level = 12'd2048;
    bus.amp   = 12'd2000;
    sendSample(12'd0);
    sendSample(12'd3000);
    applied++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_arm: busy got %b expected 0", bus.busy);
    end
  endtask

`ifdef PRETRIG_EN
  task automatic test_pretrig();
    logic [11:0] d;
    logic [7:0]  addrs [3];
    logic [11:0] exps  [3];
    addrs = '{8'd128, 8'd0, 8'd255};
    exps  = '{12'd500, 12'd372, 12'd627};
    bus.level = 12'd500;
    bus.amp   = 12'd100;
    armPulse();
    for (int v = 310; v <= 627; v++) begin
      sendSample(12'(v));
      if (v == 626) begin
        applied++;
        if (bus.done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL pretrig_early_done: got %b expected 0", bus.done);
        end
      end
    end
    applied++;
    if (bus.done !== 1'b1 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pretrig_done: done/auto got %b/%b expected 1/0", bus.done, bus.auto_trig);
    end
    for (int i = 0; i < 3; i++) begin
      readWord(addrs[i], d);
      applied++;
      if (d !== exps[i]) begin
        miscompares++;
        $display("[TB] FAIL pretrig_rd[%0d]: got %0d expected %0d", addrs[i], d, exps[i]);
      end
    end
  endtask
`else
  task automatic test_ramp();
    logic [11:0] d;
    logic [11:0] e;
    logic [7:0]  addrs [5];
    addrs = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
    bus.level = 12'd2048;
    bus.amp   = 12'd2000;
    armPulse();
    applied++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ramp_armed_busy: got %b expected 1", bus.busy);
    end
    for (int k = 0; k < 384; k++) begin
      sendSample(12'((k * 16) % 4096));
      if (k == 382) begin
        applied++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL ramp_before_last: done/busy got %b/%b expected 0/1", bus.done, bus.busy);
        end
      end
    end
    applied++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ramp_done: done/busy/auto got %b/%b/%b expected 1/0/0",
               bus.done, bus.busy, bus.auto_trig);
    end
    for (int i = 0; i < 5; i++) begin
      e = 12'(((128 + int'(addrs[i])) * 16) % 4096);
      readWord(addrs[i], d);
      applied++;
      if (d !== e) begin
        miscompares++;
        $display("[TB] FAIL ramp_rd[%0d]: got %0d expected %0d", addrs[i], d, e);
      end
    end
  endtask

  task automatic test_dc();
    logic [11:0] d;
    bus.level = 12'd1000;
    bus.amp   = 12'd0;
    armPulse();
    for (int k = 0; k < 454; k++) sendSample(12'd1000);
    applied++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dc_before_last: done/busy got %b/%b expected 0/1", bus.done, bus.busy);
    end
    sendSample(12'd1000);
    applied++;
    if (bus.done !== 1'b1 || bus.auto_trig !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dc_done: done/auto got %b/%b expected 1/1", bus.done, bus.auto_trig);
    end
    for (int a = 0; a < 256; a++) begin
      readWord(8'(a), d);
      applied++;
      if (d !== 12'd1000) begin
        miscompares++;
        $display("[TB] FAIL dc_rd[%0d]: got %0d expected 1000", a, d);
      end
    end
  endtask

  task automatic test_dc_gate();
    logic [11:0] d;
    bus.level = 12'd1500;
    bus.amp   = 12'd4;
    armPulse();
    sendSample(12'd500);
    for (int k = 0; k < 453; k++) sendSample(12'd1500);
    applied++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL gate_before_last: done got %b expected 0", bus.done);
    end
    sendSample(12'd1500);
    applied++;
    if (bus.done !== 1'b1 || bus.auto_trig !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gate_done: done/auto got %b/%b expected 1/1", bus.done, bus.auto_trig);
    end
    readWord(8'd0, d);
    applied++;
    if (d !== 12'd1500) begin
      miscompares++;
      $display("[TB] FAIL gate_rd[0]: got %0d expected 1500", d);
    end
  endtask

  task automatic test_noise();
    logic [11:0] d;
    logic [11:0] pre [7];
    pre = '{12'd2044, 12'd2052, 12'd2041, 12'd2050, 12'd2039, 12'd2046, 12'd2051};
    bus.level = 12'd2048;
    bus.amp   = 12'd1000;
    armPulse();
    for (int i = 0; i < 7; i++) sendSample(pre[i]);
    for (int i = 0; i < 254; i++) sendSample((i % 2 == 1) ? 12'd2052 : 12'd2044);
    applied++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL noise_before_last: done got %b expected 0", bus.done);
    end
    sendSample(12'd2052);
    applied++;
    if (bus.done !== 1'b1 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL noise_done: done/auto got %b/%b expected 1/0", bus.done, bus.auto_trig);
    end
    readWord(8'd0, d);
    applied++;
    if (d !== 12'd2051) begin
      miscompares++;
      $display("[TB] FAIL noise_rd[0]: got %0d expected 2051", d);
    end
    readWord(8'd1, d);
    applied++;
    if (d !== 12'd2044) begin
      miscompares++;
      $display("[TB] FAIL noise_rd[1]: got %0d expected 2044", d);
    end
    readWord(8'd2, d);
    applied++;
    if (d !== 12'd2052) begin
      miscompares++;
      $display("[TB] FAIL noise_rd[2]: got %0d expected 2052", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d;
    logic [7:0]  addrs [4];
    addrs = '{8'd0, 8'd11, 8'd128, 8'd255};
    bus.level = 12'd2048;
    bus.amp   = 12'd1000;
    armPulse();
    sendSample(12'd100);
    sendSample(12'd3000);
    for (int i = 0; i < 255; i++) begin
      sendSample(12'(3001 + i));
      if (i == 10 || i == 100) armPulse();
    end
    applied++;
    if (bus.done !== 1'b1 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL arm_ignored_done: done/auto got %b/%b expected 1/0", bus.done, bus.auto_trig);
    end
    for (int i = 0; i < 4; i++) begin
      readWord(addrs[i], d);
      applied++;
      if (d !== 12'(3000 + int'(addrs[i]))) begin
        miscompares++;
        $display("[TB] FAIL arm_ignored_rd[%0d]: got %0d expected %0d", addrs[i], d, 3000 + int'(addrs[i]));
      end
    end
    armPulse();
    applied++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rearm: done/busy got %b/%b expected 0/1", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.rd_addr = 8'd0;
    bus.level   = 12'd2048;
    bus.amp     = 12'd1000;
    sendSample(12'd100);
    sendSample(12'd2500);
    for (int i = 0; i < 99; i++) sendSample(12'(2501 + i));
    applied++;
    if (bus.rd_data !== 12'd2500 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_pre_reset: rd_data/busy got %0d/%b expected 2500/1", bus.rd_data, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    applied++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.auto_trig !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_flags: busy/done/auto got %b/%b/%b expected 0/0/0",
               bus.busy, bus.done, bus.auto_trig);
    end
    applied++;
    if (bus.rd_data !== 12'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_rd_data: got %0d expected 0", bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) sendSample(12'd3000);
    applied++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_after_reset: busy/done got %b/%b expected 0/0", bus.busy, bus.done);
    end
  endtask
`endif

  initial begin
    applied          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.level        = '0;
    bus.amp          = '0;
    bus.arm          = 1'b0;
    bus.rd_addr      = '0;
    test_reset();
`ifdef PRETRIG_EN
    test_pretrig();
`else
    test_ramp();
    test_dc();
    test_dc_gate();
    test_noise();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
